data_cache_ctrl: RTL and testbench
==================================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port MEM_R_EN  input  1  load request from the MEM stage.
REQ-004 SHALL have port MEM_W_EN  input  1  store request from the MEM stage.
REQ-005 SHALL have port address  input  32  byte address; word-aligned; bits [1:0] ignored.
REQ-006 SHALL have port wdata  input  32  store data.
REQ-007 SHALL have port rdata  output  32  load data to the MEM stage.
REQ-008 SHALL have port ready  output  1  1 = access complete; 0 = freeze the whole pipeline.
REQ-009 SHALL have ports sram_address (output, 16, word address = address[17:2]), sram_wdata (output, 32), sram_read (output, 1), sram_write (output, 1).
REQ-010 SHALL have ports sram_rdata (input, 32) and sram_ready (input, 1); sram_ready is a one-cycle completion pulse from SRAM.
REQ-011 SHALL have ports hit_count and miss_count  output  16  load statistics.

Function
REQ-012 SHALL be direct-mapped, 64 lines of one 32-bit word each, with index = address[7:2], tag = address[17:8] (10 bits), and one valid bit per line.
REQ-013 SHALL be write-through and no-write-allocate.
REQ-014 SHALL implement FSM states IDLE, READ_MISS and WRITE.
REQ-015 IDLE, no request: ready=1, sram_read=0, sram_write=0, rdata=0.
REQ-016 IDLE, MEM_R_EN with valid and tag-match (hit): rdata = line data combinationally; ready=1 in the same cycle; state stays IDLE; hit_count+1.
REQ-017 IDLE, MEM_R_EN miss: ready=0 combinationally; next state READ_MISS; miss_count+1 on that edge.
REQ-018 READ_MISS: sram_read=1 and sram_address driven from address every cycle; ready=0 until sram_ready.
REQ-019 READ_MISS with sram_ready=1: rdata=sram_rdata and ready=1 in that cycle; at the edge, line data=sram_rdata, tag written, valid=1; next state IDLE.
REQ-020 IDLE, MEM_W_EN: ready=0 combinationally; next state WRITE.
REQ-021 WRITE: sram_write=1, sram_wdata=wdata; ready=0 until sram_ready.
REQ-022 WRITE with sram_ready=1: ready=1; if the line is valid with matching tag, line data=wdata at the edge; on a miss the line is untouched; next state IDLE.
REQ-023 MEM_R_EN and MEM_W_EN both 1 SHALL be treated as a write.
REQ-024 The MEM stage holds address, wdata and the enables stable while ready=0; the block SHALL NOT latch them.
REQ-025 sram_read and sram_write SHALL never be 1 in the same cycle.
REQ-026 hit_count and miss_count SHALL saturate at 0xFFFF with no wrap.
REQ-027 The block SHALL impose no timeout; READ_MISS and WRITE persist until sram_ready.
REQ-028 sram_ready while in IDLE SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE; all 64 valid bits 0; hit_count=0; miss_count=0; sram_read=0; sram_write=0.
REQ-030 rst asserted mid-READ_MISS or mid-WRITE SHALL abort the access with no line update; after release, the first access is a fresh request.
REQ-031 Line data and tag arrays need no reset.

Verification
REQ-032 After reset, load 0x0000_0404 with SRAM returning 0xDEAD_BEEF after 4 cycles: ready=0 for 4 cycles, then rdata=0xDEAD_BEEF with ready=1; miss_count=1.
REQ-033 Repeat that load: rdata=0xDEAD_BEEF and ready=1 in the same cycle; sram_read stays 0; hit_count=1.
REQ-034 Store 0x1234_5678 to 0x0000_0404, then load it: sram_write=1 until sram_ready; the following load hits and returns 0x1234_5678.
REQ-035 Load 0x0000_0504 (same index, different tag): miss; the line is replaced. A following load of 0x0000_0404 misses again; miss_count=3.
REQ-036 Store to the unmapped-in-cache address 0x0000_0808, then load it: the load misses, proving no write-allocate.
REQ-037 Assert rst during READ_MISS, then load the same address: miss again with valid cleared; both counters 0 right after reset; drive 65536 hits and check hit_count=0xFFFF.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller placed
// between the MEM pipeline stage and a single-port SRAM.
//   64 lines x one 32-bit word; index = address[7:2], tag = address[17:8].
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN        - load / store request (store wins if both set)
//   address, wdata            - request address and store data, held by MEM
//                               stage while ready=0 (never latched here)
//   rdata, ready              - load data, access-complete / pipeline freeze
//   sram_address/wdata/read/write, sram_rdata, sram_ready - SRAM side
//   hit_count, miss_count     - saturating load hit/miss statistics
module data_cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [15:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t      state_q, state_d;
  logic [63:0] valid_q, valid_d;
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;

  logic [31:0] data_mem [64];
  logic [9:0]  tag_mem  [64];

  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        hit;
  logic        line_we;
  logic [31:0] line_wdata;

  // Byte offset and upper address bits play no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:18], address[1:0]};

  assign idx = address[7:2];
  assign tag = address[17:8];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  // SRAM address/data are pure pass-throughs of the held MEM-stage request.
  assign sram_address = address[17:2];
  assign sram_wdata   = wdata;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    ready      = 1'b1;
    rdata      = 32'd0;
    sram_read  = 1'b0;
    sram_write = 1'b0;
    line_we    = 1'b0;
    line_wdata = wdata;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          ready   = 1'b0;
          state_d = WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata = data_mem[idx];
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          end else begin
            ready   = 1'b0;
            state_d = READ_MISS;
            if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          end
        end
      end
      READ_MISS: begin
        sram_read = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          // Forward the fill word straight to the pipeline in the same cycle.
          rdata        = sram_rdata;
          line_we      = 1'b1;
          line_wdata   = sram_rdata;
          valid_d[idx] = 1'b1;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        sram_write = 1'b1;
        ready      = sram_ready;
        if (sram_ready) begin
          // Write-through: only refresh a line we already own.
          line_we = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Data/tag storage needs no reset; validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      data_mem[idx] <= line_wdata;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read, sram_write;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  int vectors = 0;
  int errs = 0;

  data_cache_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load; entered/left at posedge+1. lat = cycles with ready=0 on a miss.
  task automatic do_load(input logic [31:0] a, input bit exp_hit, input int lat,
                         input logic [31:0] val);
    address = a; MEM_R_EN = 1'b1;
    @(negedge clk);
    if (exp_hit) begin
      chk("hit_ready", ready, 1);
      chk("hit_rdata", rdata, val);
      chk("hit_no_sram_read", sram_read, 0);
    end else begin
      chk("miss_ready0", ready, 0);
      chk("miss_idle_no_read", sram_read, 0);
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_ready0", ready, 0);
        chk("rm_sram_read", sram_read, 1);
        chk("rm_no_write", sram_write, 0);
        chk("rm_sram_addr", sram_address, a[17:2]);
      end
      @(posedge clk); #1;
      sram_ready = 1'b1; sram_rdata = val;
      @(negedge clk);
      chk("rm_done_ready", ready, 1);
      chk("rm_done_rdata", rdata, val);
    end
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat);
    address = a; wdata = d; MEM_W_EN = 1'b1;
    @(negedge clk);
    chk("st_ready0", ready, 0);
    chk("st_idle_no_write", sram_write, 0);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_ready0", ready, 0);
      chk("wr_sram_write", sram_write, 1);
      chk("wr_no_read", sram_read, 0);
      chk("wr_sram_wdata", sram_wdata, d);
    end
    @(posedge clk); #1;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("wr_done_ready", ready, 1);
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_W_EN = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_sram_read", sram_read, 0);
    chk("rst_sram_write", sram_write, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, 4 cycles stalled
    do_load(32'h0000_0404, 0, 4, 32'hDEAD_BEEF);
    chk("miss_cnt_1", miss_count, 1);
    chk("hit_cnt_0", hit_count, 0);
    // Repeat hits
    do_load(32'h0000_0404, 1, 0, 32'hDEAD_BEEF);
    chk("hit_cnt_1", hit_count, 1);

    // Store hit updates the line
    do_store(32'h0000_0404, 32'h1234_5678, 3);
    do_load(32'h0000_0404, 1, 0, 32'h1234_5678);
    chk("hit_cnt_2", hit_count, 2);

    // Conflict replacement
    do_load(32'h0000_0504, 0, 2, 32'hAAAA_5555);
    do_load(32'h0000_0504, 1, 0, 32'hAAAA_5555);
    do_load(32'h0000_0404, 0, 2, 32'h1234_5678);
    chk("miss_cnt_3", miss_count, 3);

    // Stray sram_ready in IDLE is ignored
    sram_ready = 1'b1; sram_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("idle_stray_ready", ready, 1);
    chk("idle_stray_rdata", rdata, 0);
    @(posedge clk); #1;
    sram_ready = 1'b0;

    // No write-allocate
    do_store(32'h0000_0808, 32'hCAFE_F00D, 2);
    do_load(32'h0000_0808, 0, 2, 32'hCAFE_F00D);
    chk("miss_cnt_4", miss_count, 4);

    // Both enables: treated as a write
    address = 32'h0000_0404; wdata = 32'h0BAD_CAFE; MEM_R_EN = 1'b1; MEM_W_EN = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("both_write", sram_write, 1);
    chk("both_no_read", sram_read, 0);
    @(posedge clk); #1;
    sram_ready = 1'b1;
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    do_load(32'h0000_0404, 1, 0, 32'h0BAD_CAFE);
    chk("hit_cnt_4", hit_count, 4);

    // Reset mid READ_MISS
    address = 32'h0000_0C0C; MEM_R_EN = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_in_rm", sram_read, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_sram_read", sram_read, 0);
    chk("abort_hits", hit_count, 0);
    chk("abort_misses", miss_count, 0);
    MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_load(32'h0000_0C0C, 0, 2, 32'h0000_0C0C);
    do_load(32'h0000_0404, 0, 2, 32'h7777_0404);
    chk("post_rst_misses", miss_count, 2);
    chk("post_rst_hits", hit_count, 0);

    // Hit counter saturation
    address = 32'h0000_0404; MEM_R_EN = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("hit_cnt_fffe", hit_count, 32'h0000_FFFE);
    chk("hit_run_rdata", rdata, 32'h7777_0404);
    repeat (6) @(posedge clk);
    #1;
    chk("hit_cnt_sat", hit_count, 32'h0000_FFFF);
    chk("hit_run_ready", ready, 1);
    MEM_R_EN = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
